// File: rtl/alu_seq.sv
// Sequencer in front of an external combinational ALU: latches a command,
// captures the ALU result one cycle later and holds it until consumed.
module alu_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [DATA_WIDTH-1:0] cmd_a_i,
    input  logic [DATA_WIDTH-1:0] cmd_b_i,
    input  logic                  cmd_acc_i,
    input  logic                  acc_clr_i,
    output logic [1:0]            alu_op_o,
    output logic [DATA_WIDTH-1:0] alu_a_o,
    output logic [DATA_WIDTH-1:0] alu_b_o,
    input  logic [DATA_WIDTH-1:0] alu_c_i,
    output logic                  res_valid_o,
    input  logic                  res_ready_i,
    output logic [DATA_WIDTH-1:0] res_data_o,
    output logic                  busy_o,
    output logic [7:0]            done_cnt_o,
    output logic [1:0]            state_dbg_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid/ready seen outside the accepting state change nothing.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  cmd_fire;
    logic                  res_fire;

    logic [1:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [7:0]            cnt_q, cnt_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                if (res_fire) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        cmd_ready_o = 1'b0;
        res_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            EXEC: begin
                busy_o = 1'b1;
            end
            RESP: begin
                res_valid_o = 1'b1;
            end
            default: begin
                busy_o = 1'b1;
            end
        endcase
        cmd_fire = cmd_valid_i && cmd_ready_o;
        res_fire = res_ready_i && res_valid_o;
    end

    // Datapath next values. A clear landing on an accumulator-sourced accept
    // forces the latched A to zero, and a clear during EXEC beats the capture.
    always_comb begin
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        res_d = res_q;
        cnt_d = cnt_q;

        if (cmd_fire) begin
            op_d = cmd_op_i;
            b_d  = cmd_b_i;
            if (cmd_acc_i) begin
                a_d = acc_clr_i ? '0 : acc_q;
            end else begin
                a_d = cmd_a_i;
            end
        end

        if (state_q == EXEC) begin
            res_d = alu_c_i;
            acc_d = alu_c_i;
        end

        if (acc_clr_i) begin
            acc_d = '0;
        end

        if (res_fire) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= 2'b00;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            res_q <= '0;
            cnt_q <= 8'd0;
        end else begin
            op_q  <= op_d;
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            res_q <= res_d;
            cnt_q <= cnt_d;
        end
    end

    assign alu_op_o    = op_q;
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign res_data_o  = res_q;
    assign done_cnt_o  = cnt_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: external ALU model, command driver,
// result scoreboard fed at command time and drained on result handshakes.
module tb_alu_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         cmd_valid_i;
  logic         cmd_ready_o;
  logic [1:0]   cmd_op_i;
  logic [W-1:0] cmd_a_i;
  logic [W-1:0] cmd_b_i;
  logic         cmd_acc_i;
  logic         acc_clr_i;
  logic [1:0]   alu_op_o;
  logic [W-1:0] alu_a_o;
  logic [W-1:0] alu_b_o;
  logic [W-1:0] alu_c_i;
  logic         res_valid_o;
  logic         res_ready_i;
  logic [W-1:0] res_data_o;
  logic         busy_o;
  logic [7:0]   done_cnt_o;
  logic [1:0]   state_dbg_o;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_acc = '0;
  logic [7:0]   exp_done  = 8'd0;

  alu_seq #(.DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_a_i     (cmd_a_i),
    .cmd_b_i     (cmd_b_i),
    .cmd_acc_i   (cmd_acc_i),
    .acc_clr_i   (acc_clr_i),
    .alu_op_o    (alu_op_o),
    .alu_a_o     (alu_a_o),
    .alu_b_o     (alu_b_o),
    .alu_c_i     (alu_c_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_data_o  (res_data_o),
    .busy_o      (busy_o),
    .done_cnt_o  (done_cnt_o),
    .state_dbg_o (state_dbg_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a ^ b;
      default: return a & b;
    endcase
  endfunction

  // external combinational ALU
  always_comb alu_c_i = alu_f(alu_op_o, alu_a_o, alu_b_o);

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // scoreboard drain: valid && ready stable before the handshake edge
  always @(negedge clk) begin
    if (rst_n && res_valid_o && res_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        chk("res_data", res_data_o, exp_q.pop_front());
        exp_done = exp_done + 8'd1;
      end
    end
  end

  // driver tasks
  task automatic send_cmd(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic use_acc, input logic clr_accept, input logic clr_exec);
    logic [W-1:0] a_eff;
    logic [W-1:0] res;
    int n;
    n = 0;
    while (!cmd_ready_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready_o) chk("cmd_ready_timeout", 32'd0, 32'd1);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_a_i     = a;
    cmd_b_i     = b;
    cmd_acc_i   = use_acc;
    acc_clr_i   = clr_accept;
    a_eff = use_acc ? (clr_accept ? '0 : model_acc) : a;
    res   = alu_f(op, a_eff, b);
    if (clr_accept) model_acc = '0;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    cmd_acc_i   = 1'b0;
    acc_clr_i   = clr_exec;
    exp_q.push_back(res);
    model_acc = clr_exec ? '0 : res;
    chk("exec_res_valid", 32'(res_valid_o), 32'd0);
    chk("exec_cmd_ready", 32'(cmd_ready_o), 32'd0);
    chk("exec_alu_a", alu_a_o, a_eff);
    chk("exec_alu_b", alu_b_o, b);
    chk("exec_alu_op", 32'(alu_op_o), 32'(op));
    @(posedge clk); #1;
    acc_clr_i = 1'b0;
    chk("resp_res_valid", 32'(res_valid_o), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy_o) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic use_acc);
    send_cmd(op, a, b, use_acc, 1'b0, 1'b0);
    wait_idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_acc = '0;
    exp_done  = 8'd0;
  endtask

  initial begin
    logic [W-1:0] held;
    rst_n       = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_op_i    = 2'b00;
    cmd_a_i     = '0;
    cmd_b_i     = '0;
    cmd_acc_i   = 1'b0;
    acc_clr_i   = 1'b0;
    res_ready_i = 1'b1;
    do_reset();

    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_res_valid", 32'(res_valid_o), 32'd0);
    chk("rst_res_data", res_data_o, 32'd0);
    chk("rst_alu_op", 32'(alu_op_o), 32'd0);
    chk("rst_alu_a", alu_a_o, 32'd0);
    chk("rst_alu_b", alu_b_o, 32'd0);
    chk("rst_done", 32'(done_cnt_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);

    // basic add and wrap-around cases
    run_cmd(2'b00, 32'd5, 32'd3, 1'b0);
    chk("done_after_add", 32'(done_cnt_o), 32'(exp_done));
    run_cmd(2'b01, 32'd0, 32'd1, 1'b0);
    run_cmd(2'b00, 32'hFFFF_FFFF, 32'd1, 1'b0);

    // accumulator chain
    run_cmd(2'b00, 32'd10, 32'd0, 1'b0);
    run_cmd(2'b00, 32'hDEAD_BEEF, 32'd5, 1'b1);
    acc_clr_i = 1'b1;
    @(posedge clk); #1;
    acc_clr_i = 1'b0;
    model_acc = '0;
    run_cmd(2'b10, 32'h1234_5678, 32'hF0, 1'b1);

    // clear coincident with accept, then with EXEC capture
    send_cmd(2'b00, 32'h5555_5555, 32'd3, 1'b1, 1'b1, 1'b0);
    wait_idle();
    send_cmd(2'b11, 32'hFF, 32'h0F, 1'b0, 1'b0, 1'b1);
    wait_idle();
    run_cmd(2'b00, 32'h7777_7777, 32'd2, 1'b1);

    // consumer stall with a competing command offered
    res_ready_i = 1'b0;
    send_cmd(2'b01, 32'd100, 32'd42, 1'b0, 1'b0, 1'b0);
    held = exp_q[0];
    for (int i = 0; i < 4; i++) begin
      cmd_valid_i = 1'b1;
      cmd_op_i    = 2'b10;
      cmd_a_i     = $urandom;
      cmd_b_i     = $urandom;
      chk("stall_res_valid", 32'(res_valid_o), 32'd1);
      chk("stall_res_data", res_data_o, held);
      chk("stall_cmd_ready", 32'(cmd_ready_o), 32'd0);
      chk("stall_busy", 32'(busy_o), 32'd1);
      @(posedge clk); #1;
    end
    cmd_valid_i = 1'b0;
    res_ready_i = 1'b1;
    wait_idle();
    chk("done_after_stall", 32'(done_cnt_o), 32'(exp_done));
    run_cmd(2'b00, 32'd0, 32'd1, 1'b1);

    // random mix
    for (int i = 0; i < 8; i++) begin
      run_cmd(2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
    chk("done_after_mix", 32'(done_cnt_o), 32'(exp_done));

    // asynchronous reset in EXEC
    cmd_valid_i = 1'b1;
    cmd_op_i    = 2'b01;
    cmd_a_i     = 32'hABCD;
    cmd_b_i     = 32'h1;
    @(posedge clk); #1;
    cmd_valid_i = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("arst_res_valid", 32'(res_valid_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_res_data", res_data_o, 32'd0);
    chk("arst_alu_a", alu_a_o, 32'd0);
    chk("arst_alu_b", alu_b_o, 32'd0);
    chk("arst_alu_op", 32'(alu_op_o), 32'd0);
    chk("arst_done", 32'(done_cnt_o), 32'd0);
    do_reset();
    chk("arst_still_idle", 32'(busy_o), 32'd0);
    run_cmd(2'b00, 32'h9999, 32'd7, 1'b1);
    chk("acc_after_reset", 32'(done_cnt_o), 32'(exp_done));

    // done counter wrap over 256 back-to-back ANDs
    do_reset();
    for (int i = 0; i < 256; i++) begin
      run_cmd(2'b11, $urandom, $urandom, 1'b0);
      if (i == 254) chk("done_255", 32'(done_cnt_o), 32'd255);
    end
    chk("done_wrap", 32'(done_cnt_o), 32'd0);
    chk("done_model", 32'(done_cnt_o), 32'(exp_done));
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
